// File: rtl/axis_dma_s2mm_arb.sv
// axis_dma_s2mm_arb: packet-granular round-robin arbiter sharing one DMA S2MM stream among N_SRC producers,
// tagging each beat with its source index and counting completed packets per source.
module axis_dma_s2mm_arb #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 6,
    parameter int CNT_WIDTH  = 32,
    localparam int GW        = $clog2(N_SRC),
    localparam int KW        = DATA_WIDTH / 8
) (
    input  logic                        sys_clk,
    input  logic                        perif_rst_n,
    input  logic                        enable,
    input  logic [N_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [N_SRC*KW-1:0]         s_tkeep,
    input  logic [N_SRC-1:0]            s_tlast,
    input  logic [N_SRC-1:0]            s_tvalid,
    output logic [N_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic [KW-1:0]               m_tkeep,
    output logic                        m_tlast,
    output logic [ID_WIDTH-1:0]         m_tid,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        busy,
    output logic [GW-1:0]               grant_idx,
    output logic [N_SRC*CNT_WIDTH-1:0]  pkt_cnt
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t               r_state, w_state_nxt;
    logic [GW-1:0]        r_grant_idx, r_last_grant, w_pick, w_j;
    logic                 w_any, w_acc, w_last;
    logic [CNT_WIDTH-1:0] r_cnt [N_SRC];
    // Scan from farthest to nearest so the source right after last_grant wins.
    always_comb begin
        w_pick = r_grant_idx;
        w_any  = 1'b0;
        w_j    = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_j = GW'((int'(r_last_grant) + k) % N_SRC);
            if (s_tvalid[w_j]) begin
                w_pick = w_j;
                w_any  = 1'b1;
            end
        end
    end
    assign s_tready = (r_state == GRANT && (!m_tvalid || m_tready)) ?
                      {{(N_SRC-1){1'b0}}, 1'b1} << r_grant_idx : '0;
    assign w_acc     = |(s_tvalid & s_tready);
    assign w_last    = s_tlast[r_grant_idx];
    assign busy      = r_state == GRANT;
    assign grant_idx = r_grant_idx;
    always_comb begin
        w_state_nxt = (r_state == IDLE) ? ((enable && w_any) ? GRANT : IDLE)
                                        : ((w_acc && w_last) ? IDLE : GRANT);
    end
    always_ff @(posedge sys_clk or negedge perif_rst_n) begin
        if (!perif_rst_n) begin
            r_state      <= IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= GW'(N_SRC - 1);
            m_tdata      <= '0;
            m_tkeep      <= '0;
            m_tlast      <= 1'b0;
            m_tid        <= '0;
            m_tvalid     <= 1'b0;
            for (int i = 0; i < N_SRC; i++) r_cnt[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && enable && w_any) r_grant_idx <= w_pick;
            if (w_acc) begin
                m_tdata  <= s_tdata[r_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                m_tkeep  <= s_tkeep[r_grant_idx*KW +: KW];
                m_tlast  <= w_last;
                m_tid    <= ID_WIDTH'(r_grant_idx);
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (w_acc && w_last) begin
                r_last_grant       <= r_grant_idx;
                r_cnt[r_grant_idx] <= r_cnt[r_grant_idx] + CNT_WIDTH'(1);
            end
        end
    end
    for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
        assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
    end
endmodule

// File: tb/tb_axis_dma_s2mm_arb.sv
// tb_axis_dma_s2mm_arb: directed bench for the packet round-robin S2MM arbiter
// (4 sources, 64-bit data, 4-bit counters so the wrap is reachable).
module tb_axis_dma_s2mm_arb;
    logic         sys_clk = 1'b0;
    logic         perif_rst_n = 1'b0;
    logic         enable;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic [3:0]   s_tlast, s_tvalid, s_tready;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;
    logic         m_tlast, m_tvalid, m_tready, busy;
    logic [5:0]   m_tid;
    logic [1:0]   grant_idx;
    logic [15:0]  pkt_cnt;

    axis_dma_s2mm_arb #(.N_SRC(4), .DATA_WIDTH(64), .ID_WIDTH(6), .CNT_WIDTH(4)) dut (
        .sys_clk(sys_clk), .perif_rst_n(perif_rst_n), .enable(enable),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy),
        .grant_idx(grant_idx), .pkt_cnt(pkt_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_err = 0, cyc = 0;
    int npk[4], plen[4], bi[4], pno[4], first_acc[4], last_acc[4];
    bit en, rnd, prev_stall;
    logic [63:0] prev_data;
    logic [3:0]  hs;
    int          obs_tid[$];
    logic [63:0] obs_data[$];
    logic        obs_last[$];
    logic [7:0]  obs_keep[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bdata(int s, int p, int b);
        return {32'hDA7A_0000, 8'(s), 8'(p), 16'(b)};
    endfunction

    function automatic logic [3:0] cnt(int i);
        return pkt_cnt[i*4 +: 4];
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]         = npk[i] > 0;
            s_tdata[i*64 +: 64] = bdata(i, pno[i], bi[i]);
            s_tlast[i]          = bi[i] == plen[i] - 1;
            s_tkeep[i*8 +: 8]   = s_tlast[i] ? 8'h0F : 8'hFF;
        end
        enable   = en;
        m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic tick();
        @(negedge sys_clk);
        drive();
        #1;
        hs = s_tvalid & s_tready;
        if (prev_stall) check("hold_data", m_tdata, prev_data);
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        if (m_tvalid && m_tready) begin
            obs_tid.push_back(int'(m_tid));
            obs_data.push_back(m_tdata);
            obs_last.push_back(m_tlast);
            obs_keep.push_back(m_tkeep);
        end
        @(posedge sys_clk);
        cyc++;
        for (int i = 0; i < 4; i++) if (hs[i]) begin
            if (first_acc[i] < 0) first_acc[i] = cyc;
            last_acc[i] = cyc;
            bi[i]++;
            if (bi[i] == plen[i]) begin
                bi[i] = 0;
                pno[i]++;
                npk[i]--;
            end
        end
    endtask

    task automatic do_reset();
        perif_rst_n = 1'b0;
        en = 1'b1; rnd = 1'b0; prev_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            npk[i] = 0; plen[i] = 1; bi[i] = 0; pno[i] = 0; first_acc[i] = -1; last_acc[i] = -1;
        end
        obs_tid.delete(); obs_data.delete(); obs_last.delete(); obs_keep.delete();
        drive();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        perif_rst_n = 1'b1;
    endtask

    task automatic run_until(string tag, int n, int budget);
        for (int c = 0; c < budget && obs_tid.size() < n; c++) tick();
        check(tag, obs_tid.size(), n);
    endtask

    initial begin
        do_reset();
        perif_rst_n = 1'b0;
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tid", m_tid, 0);
        check("rst_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_cnt", pkt_cnt, 0);

        // Two sources, 3-beat packets each
        do_reset();
        npk[0] = 1; plen[0] = 3; npk[2] = 1; plen[2] = 3;
        run_until("t1_beats", 6, 60);
        for (int k = 0; k < 6; k++) begin
            check("t1_tid", obs_tid[k], k < 3 ? 0 : 2);
            check("t1_data", obs_data[k], bdata(k < 3 ? 0 : 2, 0, k % 3));
            check("t1_last", obs_last[k], k % 3 == 2);
        end
        check("t1_keep_mid", obs_keep[0], 8'hFF);
        check("t1_keep_last", obs_keep[2], 8'h0F);
        check("t1_gap", first_acc[2] - last_acc[0], 2);
        check("t1_cnt0", cnt(0), 1);
        check("t1_cnt1", cnt(1), 0);
        check("t1_cnt2", cnt(2), 1);

        // All four continuously valid, 2-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) begin npk[i] = 3; plen[i] = 2; end
        run_until("t2_beats", 24, 200);
        for (int k = 0; k < 24; k++) begin
            check("t2_tid", obs_tid[k], (k / 2) % 4);
            check("t2_data", obs_data[k], bdata((k / 2) % 4, k / 8, k % 2));
        end
        for (int i = 0; i < 4; i++) check("t2_cnt", cnt(i), 3);

        // Random backpressure on a 16-beat packet
        do_reset();
        npk[1] = 1; plen[1] = 16; rnd = 1'b1;
        run_until("t3_beats", 16, 400);
        for (int k = 0; k < 16; k++) begin
            check("t3_tid", obs_tid[k], 1);
            check("t3_data", obs_data[k], bdata(1, 0, k));
        end
        check("t3_last", obs_last[15], 1);
        check("t3_cnt1", cnt(1), 1);

        // enable dropped mid-packet, other sources waiting
        do_reset();
        npk[3] = 1; plen[3] = 5;
        begin
            bit dropped = 1'b0;
            for (int c = 0; c < 100 && obs_tid.size() < 5; c++) begin
                tick();
                if (!dropped && bi[3] == 2) begin
                    en = 1'b0; dropped = 1'b1;
                    npk[0] = 1; plen[0] = 2; npk[1] = 1; plen[1] = 2;
                end
            end
        end
        repeat (10) tick();
        check("t4_beats", obs_tid.size(), 5);
        for (int k = 0; k < 5; k++) check("t4_tid", obs_tid[k], 3);
        check("t4_busy", busy, 0);
        check("t4_tready", s_tready, 0);
        check("t4_cnt3", cnt(3), 1);
        en = 1'b1;
        run_until("t4_resume", 9, 60);
        check("t4_next0", obs_tid[5], 0);
        check("t4_next1", obs_tid[7], 1);

        // Reset asserted mid-packet
        do_reset();
        npk[2] = 1; plen[2] = 8;
        for (int c = 0; c < 40 && bi[2] < 3; c++) tick();
        check("t5_busy", busy, 1);
        check("t5_tvalid_pre", m_tvalid, 1);
        #3 perif_rst_n = 1'b0;
        #1;
        check("t5_tvalid", m_tvalid, 0);
        check("t5_tdata", m_tdata, 0);
        check("t5_tid", m_tid, 0);
        check("t5_tlast", m_tlast, 0);
        check("t5_busy_rst", busy, 0);
        check("t5_grant", grant_idx, 0);
        check("t5_tready", s_tready, 0);
        check("t5_cnt", pkt_cnt, 0);
        do_reset();
        npk[0] = 1; plen[0] = 2; npk[2] = 1; plen[2] = 2;
        run_until("t5_beats", 4, 40);
        check("t5_first_tid", obs_tid[0], 0);
        check("t5_first_data", obs_data[0], bdata(0, 0, 0));
        check("t5_second_tid", obs_tid[2], 2);

        // Counter wrap: 17 single-beat packets into a 4-bit counter
        do_reset();
        npk[1] = 17; plen[1] = 1;
        run_until("t6_beats", 17, 100);
        check("t6_tid", obs_tid[16], 1);
        check("t6_data", obs_data[16], bdata(1, 16, 0));
        check("t6_cnt1", cnt(1), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
